aes_round_controller: RTL and testbench

Sequencing FSM for the iterative AES-128/192/256 encryption datapath. It loads the plaintext state and steps the shared stage registers through the AES round order: initial AddRoundKey, then SubBytes, ShiftRows, MixColumns and AddRoundKey per round, with MixColumns skipped in the final round. Each stage is enabled by a one-cycle `active` strobe. Round keys are requested from the key-expansion block through a request/valid handshake, and completion is signalled with a done pulse.

---
 rtl/aes_round_controller_if.sv | 31 +++
 rtl/aes_round_controller.sv | 89 ++++++++
 tb/tb_aes_round_controller.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_controller_if.sv
// Control handshake bundle between the AES round sequencer and its datapath.
// Key-expansion request/valid and the stage enables travel together here.
interface aes_round_controller_if;
   logic       i_start;
   logic       i_abort;
   logic       i_key_valid;
   logic       o_busy;
   logic       o_load;
   logic       o_sub_active;
   logic       o_shift_active;
   logic       o_mix_active;
   logic       o_key_req;
   logic       o_ark_active;
   logic [3:0] o_round;
   logic       o_last_round;
   logic       o_done;

   modport master (
      output i_start, i_abort, i_key_valid,
      input  o_busy, o_load, o_sub_active, o_shift_active,
      input  o_mix_active, o_key_req, o_ark_active,
      input  o_round, o_last_round, o_done
   );

   modport slave (
      input  i_start, i_abort, i_key_valid,
      output o_busy, o_load, o_sub_active, o_shift_active,
      output o_mix_active, o_key_req, o_ark_active,
      output o_round, o_last_round, o_done
   );
endinterface

// File: rtl/aes_round_controller.sv
// Round sequencer for the iterative AES-128/192/256 encryption datapath.
// Steps shared stage registers through ARK0, then SUB/SHIFT/MIX/ARK per round.
module aes_round_controller #(
   parameter int NUM_ROUNDS = 10
) (
   input logic                   i_clock,
   input logic                   i_reset_n,
   aes_round_controller_if.slave ctl
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_ARK0  = 3'd2;
   localparam logic [2:0] S_SUB   = 3'd3;
   localparam logic [2:0] S_SHIFT = 3'd4;
   localparam logic [2:0] S_MIX   = 3'd5;
   localparam logic [2:0] S_ARK   = 3'd6;
   localparam logic [2:0] S_DONE  = 3'd7;

   localparam logic [3:0] NR = 4'(NUM_ROUNDS);

   logic [2:0] state_q, state_d;
   logic [3:0] round_q, round_d;
   logic       last_w;

   assign last_w = (round_q == NR);

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      // Abort outranks everything, even a start seen in IDLE.
      if (ctl.i_abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ctl.i_start) begin
                  state_d = S_LOAD;
                  round_d = 4'd0;
               end
            end
            S_LOAD: state_d = S_ARK0;
            S_ARK0: begin
               if (ctl.i_key_valid) begin
                  state_d = S_SUB;
                  round_d = round_q + 4'd1;
               end
            end
            S_SUB:   state_d = S_SHIFT;
            S_SHIFT: state_d = last_w ? S_ARK : S_MIX;
            S_MIX:   state_d = S_ARK;
            S_ARK: begin
               if (ctl.i_key_valid) begin
                  if (last_w) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_SUB;
                     round_d = round_q + 4'd1;
                  end
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= S_IDLE;
         round_q <= 4'd0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
      end
   end

   assign ctl.o_busy         = (state_q != S_IDLE);
   assign ctl.o_load         = (state_q == S_LOAD);
   assign ctl.o_sub_active   = (state_q == S_SUB);
   assign ctl.o_shift_active = (state_q == S_SHIFT);
   assign ctl.o_mix_active   = (state_q == S_MIX);
   assign ctl.o_key_req      = (state_q == S_ARK0) || (state_q == S_ARK);
   assign ctl.o_ark_active   = ctl.o_key_req & ctl.i_key_valid;
   assign ctl.o_round        = round_q;
   assign ctl.o_last_round   = last_w;
   assign ctl.o_done         = (state_q == S_DONE);

endmodule

// File: tb/tb_aes_round_controller.sv
// Randomised bench for aes_round_controller at NUM_ROUNDS 10, 12 and 14.
// A per-instance round schedule list predicts every output each cycle.
module tb_aes_round_controller;

   localparam int P_IDLE  = 0;
   localparam int P_LOAD  = 1;
   localparam int P_ARK0  = 2;
   localparam int P_SUB   = 3;
   localparam int P_SHIFT = 4;
   localparam int P_MIX   = 5;
   localparam int P_ARK   = 6;
   localparam int P_DONE  = 7;

   logic clk = 1'b0;
   logic rst_n;
   logic start, abort, kv;

   always #5 clk = ~clk;

   aes_round_controller_if bus[3] ();
   logic [12:0] obs [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign bus[g].i_start     = start;
      assign bus[g].i_abort     = abort;
      assign bus[g].i_key_valid = kv;
      assign obs[g] = {bus[g].o_busy, bus[g].o_load,
                       bus[g].o_sub_active, bus[g].o_shift_active,
                       bus[g].o_mix_active, bus[g].o_key_req,
                       bus[g].o_ark_active, bus[g].o_round,
                       bus[g].o_last_round, bus[g].o_done};
      aes_round_controller #(.NUM_ROUNDS(10 + 2 * g)) u_dut (
         .i_clock   (clk),
         .i_reset_n (rst_n),
         .ctl       (bus[g])
      );
   end

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int nr_of  [3];
   int sch_ph [3][64];
   int sch_rd [3][64];
   bit idle   [3];
   int pos    [3];
   int mrd    [3];
   int mixcnt [3];
   int arkcnt [3];
   int donecnt[3];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, exp);
      end
   endtask

   // Full phase list of one encryption: LOAD, ARK0, rounds, DONE.
   task automatic build(input int i, input int nr);
      int n;
      n = 0;
      nr_of[i] = nr;
      sch_ph[i][n] = P_LOAD; sch_rd[i][n] = 0; n++;
      sch_ph[i][n] = P_ARK0; sch_rd[i][n] = 0; n++;
      for (int r = 1; r <= nr; r++) begin
         sch_ph[i][n] = P_SUB;   sch_rd[i][n] = r; n++;
         sch_ph[i][n] = P_SHIFT; sch_rd[i][n] = r; n++;
         if (r < nr) begin
            sch_ph[i][n] = P_MIX; sch_rd[i][n] = r; n++;
         end
         sch_ph[i][n] = P_ARK;   sch_rd[i][n] = r; n++;
      end
      sch_ph[i][n] = P_DONE; sch_rd[i][n] = nr;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         idle[i] = 1'b1;
         pos[i]  = 0;
         mrd[i]  = 0;
      end
   endtask

   function automatic int cur_ph(input int i);
      return idle[i] ? P_IDLE : sch_ph[i][pos[i]];
   endfunction

   function automatic int cur_rd(input int i);
      return idle[i] ? mrd[i] : sch_rd[i][pos[i]];
   endfunction

   function automatic logic [12:0] expv(input int i, input logic k);
      int  ph, rd;
      logic kr;
      ph = cur_ph(i);
      rd = cur_rd(i);
      kr = (ph == P_ARK0) || (ph == P_ARK);
      return {!idle[i], ph == P_LOAD, ph == P_SUB, ph == P_SHIFT,
              ph == P_MIX, kr, kr & k, 4'(rd), rd == nr_of[i],
              ph == P_DONE};
   endfunction

   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         int ph, rd;
         ph = cur_ph(i);
         rd = cur_rd(i);
         if (abort) begin
            idle[i] = 1'b1;
            mrd[i]  = rd;
         end else if (idle[i]) begin
            if (start) begin
               idle[i] = 1'b0;
               pos[i]  = 0;
            end
         end else if (!(((ph == P_ARK0) || (ph == P_ARK)) && !kv)) begin
            if (ph == P_DONE) begin
               idle[i] = 1'b1;
               mrd[i]  = rd;
            end else begin
               pos[i]++;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("nr%0d_c%0d", nr_of[i], cyc), 32'(obs[i]),
             32'(expv(i, kv)));
         mixcnt[i]  += int'(obs[i][8]);
         arkcnt[i]  += int'(obs[i][6]);
         donecnt[i] += int'(obs[i][0]);
      end
   endtask

   function automatic bit all_idle();
      return idle[0] && idle[1] && idle[2];
   endfunction

   initial begin
      bit found;
      for (int i = 0; i < 3; i++) build(i, 10 + 2 * i);
      model_reset();
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      kv    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++)
         chk($sformatf("reset_nr%0d", nr_of[i]), 32'(obs[i]), 32'd0);
      rst_n = 1'b1;
      tick();

      // Nominal run, keys always ready.
      for (int i = 0; i < 3; i++) begin
         mixcnt[i] = 0; arkcnt[i] = 0; donecnt[i] = 0;
      end
      kv = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 80 && !all_idle(); c++) tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("nom_busy_nr%0d", nr_of[i]), 32'(obs[i][12]), 32'd0);
         chk($sformatf("nom_mix_nr%0d", nr_of[i]), mixcnt[i], nr_of[i] - 1);
         chk($sformatf("nom_ark_nr%0d", nr_of[i]), arkcnt[i], nr_of[i] + 1);
         chk($sformatf("nom_done_nr%0d", nr_of[i]), donecnt[i], 1);
      end

      // Random start/abort/key traffic.
      for (int c = 0; c < 800; c++) begin
         start = ($urandom % 8) == 0;
         abort = ($urandom % 50) == 0;
         kv    = ($urandom % 10) < 7;
         tick();
      end
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;

      // Start held high: back-to-back operations.
      start = 1'b1;
      kv    = 1'b1;
      for (int c = 0; c < 130; c++) tick();
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();

      // Abort while round 3 is in MixColumns.
      start = 1'b1;
      tick();
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         tick();
         found = obs[0][8] && (obs[0][5:2] == 4'd3);
      end
      chk("mix3_reached", 32'(found), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", 32'(obs[0][12]), 32'd0);
      chk("abort_done", 32'(obs[0][0]), 32'd0);
      chk("abort_round", 32'(obs[0][5:2]), 32'd3);
      tick();

      // Asynchronous reset in the middle of SubBytes.
      start = 1'b1;
      tick();
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         tick();
         found = obs[0][10];
      end
      chk("sub_reached", 32'(found), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < 3; i++)
         chk($sformatf("async_rst_nr%0d", nr_of[i]), 32'(obs[i]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
